ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures the ALU result and zero flag together with the destination register and control bits.
- Resolves conditional branches from the zero flag.
- Presents the entry to the memory stage through a valid/ready handshake. A 2-entry skid buffer keeps in_ready_o registered.
- Exports a forwarding tap for hazard resolution.

Parameters:
- WORD_SIZE, 32, datapath width; matches the ALU.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous kill of all buffered entries.
- in_valid_i  input  1  upstream entry valid.
- in_ready_o  output  1  stage can accept an entry.
- alu_result_i  input  WORD_SIZE  ALU result.
- alu_zero_i  input  1  ALU zero flag.
- rd_addr_i  input  REG_ADDR_W  destination register.
- reg_we_i  input  1  register write enable.
- branch_i  input  1  instruction is a conditional branch.
- branch_ne_i  input  1  1 = BNE, 0 = BEQ; ignored when branch_i = 0.
- pc_target_i  input  WORD_SIZE  branch target address.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  downstream accepts.
- result_o  output  WORD_SIZE  registered ALU result.
- rd_addr_o  output  REG_ADDR_W  registered destination.
- reg_we_o  output  1  registered write enable.
- branch_taken_o  output  1  resolved branch outcome.
- pc_target_o  output  WORD_SIZE  registered target.
- fwd_valid_o  output  1  forwarding tap valid.
- fwd_rd_o  output  REG_ADDR_W  forwarding destination.
- fwd_data_o  output  WORD_SIZE  forwarding data.

Behaviour:
- Reset: rst_ni is asynchronous and active-low; the clock is clk_i.
  - While reset is asserted, main and skid valid bits are 0 and all data registers are 0.
  - Outputs under reset: out_valid_o=0, result_o=0, rd_addr_o=0, reg_we_o=0, branch_taken_o=0, pc_target_o=0, fwd_valid_o=0, in_ready_o=1.
- Storage: a main register drives the outputs; a skid register holds one overflow entry. Each has a valid bit.
- Ready: in_ready_o = !skid_valid. It is a registered signal with no combinational path from out_ready_i.
- Accept: an entry is accepted when in_valid_i & in_ready_o.
- Pop: the output entry is consumed when out_valid_o & out_ready_i.
- Per-edge updates, when flush_i = 0:
  - Main empty or popping, skid valid: skid moves to main. An accepted entry, if any, goes to skid.
  - Main empty or popping, skid empty: an accepted entry goes to main. With no accept, main valid clears if it was popped.
  - Main full and not popping: an accepted entry goes to skid, and in_ready_o drops next cycle.
- Latency: 1 cycle from acceptance to out_valid_o when the stage is empty. Throughput is one entry per cycle while out_ready_i=1.
- Captured values are computed at acceptance:
  - branch_taken = branch_i & (branch_ne_i ? ~alu_zero_i : alu_zero_i).
  - reg_we = reg_we_i & (rd_addr_i != 0). Writes to x0 are suppressed.
- Output hold: data outputs hold their value while out_valid_o=1 and out_ready_i=0. When out_valid_o=0 they hold their last value and are don't-care.
- Forwarding:
  - fwd_valid_o = out_valid_o & reg_we_o.
  - fwd_rd_o = rd_addr_o; fwd_data_o = result_o.
- Flush:
  - flush_i=1 clears both valid bits at the next edge.
  - A handshake occurring in the flush cycle is discarded: the input is not stored, and a pop is still seen by downstream.
  - in_ready_o reads 1 the cycle after a flush.
  - Flush has priority over every other event.
- Reset mid-operation: buffered entries are lost immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Ordering: entries leave in acceptance order. There is no duplication or loss except by flush.

Test Plan:
- Single entry with out_ready_i=1: alu_result_i=0x0000_00FF, rd=3, reg_we=1. Expect out_valid_o 1 cycle later with result_o=0xFF, rd_addr_o=3, fwd_valid_o=1. out_valid_o=0 the cycle after the pop.
- Branch resolution:
  - branch_i=1, branch_ne_i=0, alu_zero_i=1: branch_taken_o=1.
  - branch_ne_i=1, alu_zero_i=1: branch_taken_o=0.
  - branch_i=0: branch_taken_o=0 regardless of the zero flag.
- x0 suppression: rd_addr_i=0, reg_we_i=1. Expect reg_we_o=0 and fwd_valid_o=0.
- Backpressure:
  - Stimulus: stream 0x1, 0x2, 0x3 back-to-back with out_ready_i=0 from cycle 1.
  - Expect: 0x1 in main, 0x2 in skid, in_ready_o=0, and 0x3 held upstream.
  - Then raise out_ready_i: outputs 0x1, 0x2, 0x3 in order on consecutive cycles, and in_ready_o returns to 1.
- Flush: with main and skid both full, assert flush_i for one cycle alongside in_valid_i. Expect out_valid_o=0 and in_ready_o=1 the next cycle, and no flushed value ever emitted.
- Asynchronous reset: drop rst_ni between edges while an entry is pending. Expect out_valid_o=0 and result_o=0 immediately; a new entry after release passes through normally.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register downstream of the ALU.
//
// Captures the ALU result, destination register, write enable, the resolved
// conditional-branch outcome and branch target. It hands entries to the
// memory stage through a valid/ready handshake. A main register drives the
// outputs and a skid register absorbs one overflow entry, so in_ready_o
// depends only on flop state.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous kill of all buffered entries
//   in_valid_i/in_ready_o    upstream handshake
//   alu_result_i, alu_zero_i, rd_addr_i, reg_we_i,
//   branch_i, branch_ne_i, pc_target_i    captured entry fields
//   out_valid_o/out_ready_i  downstream handshake
//   result_o, rd_addr_o, reg_we_o, branch_taken_o, pc_target_o
//                        registered entry presented downstream
//   fwd_valid_o, fwd_rd_o, fwd_data_o     forwarding tap of the output entry
module ex_mem_stage #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_SIZE-1:0]  alu_result_i,
    input  logic                  alu_zero_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  reg_we_i,
    input  logic                  branch_i,
    input  logic                  branch_ne_i,
    input  logic [WORD_SIZE-1:0]  pc_target_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_SIZE-1:0]  result_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  reg_we_o,
    output logic                  branch_taken_o,
    output logic [WORD_SIZE-1:0]  pc_target_o,
    output logic                  fwd_valid_o,
    output logic [REG_ADDR_W-1:0] fwd_rd_o,
    output logic [WORD_SIZE-1:0]  fwd_data_o
);

    typedef struct packed {
        logic [WORD_SIZE-1:0]  result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  we;
        logic                  taken;
        logic [WORD_SIZE-1:0]  pc;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   pop;

    // Branch outcome and x0 write suppression are resolved at capture time.
    always_comb begin
        in_entry        = '0;
        in_entry.result = alu_result_i;
        in_entry.rd     = rd_addr_i;
        in_entry.we     = reg_we_i & (rd_addr_i != '0);
        in_entry.taken  = branch_i & (branch_ne_i ? ~alu_zero_i : alu_zero_i);
        in_entry.pc     = pc_target_i;
    end

    assign accept = in_valid_i & ~skid_valid_q;
    assign pop    = main_valid_q & out_ready_i;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush_i) begin
            // Data registers keep their contents; only the valid bits die.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                // Skid drains first to preserve order; a new entry refills it.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_entry;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_entry;
                end
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready_o     = ~skid_valid_q;
    assign out_valid_o    = main_valid_q;
    assign result_o       = main_q.result;
    assign rd_addr_o      = main_q.rd;
    assign reg_we_o       = main_q.we;
    assign branch_taken_o = main_q.taken;
    assign pc_target_o    = main_q.pc;

    assign fwd_valid_o    = main_valid_q & main_q.we;
    assign fwd_rd_o       = main_q.rd;
    assign fwd_data_o     = main_q.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed vectors, expected entries pushed to a
// scoreboard queue on acceptance and popped by a monitor on each output pop.
module tb_ex_mem_stage;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [4:0]  rd_addr;
    logic        reg_we;
    logic        branch;
    logic        branch_ne;
    logic [31:0] pc_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;
    logic        reg_we_out;
    logic        branch_taken;
    logic [31:0] pc_target_out;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ex_mem_stage #(.WORD_SIZE(32), .REG_ADDR_W(5)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .alu_result_i   (alu_result),
        .alu_zero_i     (alu_zero),
        .rd_addr_i      (rd_addr),
        .reg_we_i       (reg_we),
        .branch_i       (branch),
        .branch_ne_i    (branch_ne),
        .pc_target_i    (pc_target),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .result_o       (result),
        .rd_addr_o      (rd_addr_out),
        .reg_we_o       (reg_we_out),
        .branch_taken_o (branch_taken),
        .pc_target_o    (pc_target_out),
        .fwd_valid_o    (fwd_valid),
        .fwd_rd_o       (fwd_rd),
        .fwd_data_o     (fwd_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every downstream pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got result 0x%0h expected no entry at %0t", result, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",    64'(result),        64'(e.result));
                check("rd_addr",   64'(rd_addr_out),   64'(e.rd));
                check("reg_we",    64'(reg_we_out),    64'(e.we));
                check("taken",     64'(branch_taken),  64'(e.taken));
                check("pc_target", 64'(pc_target_out), 64'(e.pc));
                check("fwd_valid", 64'(fwd_valid),     64'(e.we));
                check("fwd_rd",    64'(fwd_rd),        64'(e.rd));
                check("fwd_data",  64'(fwd_data),      64'(e.result));
            end
        end
    end

    // Called just after a rising edge (+1). Returns just after the accepting edge (+1).
    task automatic send(input logic [31:0] res, input logic zero, input logic [4:0] rd,
                        input logic we, input logic br, input logic ne, input logic [31:0] pc,
                        input logic exp_we, input logic exp_taken);
        int n;
        exp_t e;
        alu_result = res;
        alu_zero   = zero;
        rd_addr    = rd;
        reg_we     = we;
        branch     = br;
        branch_ne  = ne;
        pc_target  = pc;
        in_valid   = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL accept_timeout: in_ready stuck at %0b expected 1", in_ready);
        end else begin
            @(posedge clk);
            e.result = res;
            e.rd     = rd;
            e.we     = exp_we;
            e.taken  = exp_taken;
            e.pc     = pc;
            exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        alu_result = '0;
        alu_zero   = 1'b0;
        rd_addr    = '0;
        reg_we     = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        pc_target  = '0;
        out_ready  = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_result",    64'(result),    64'd0);
        check("rst_rd",        64'(rd_addr_out), 64'd0);
        check("rst_we",        64'(reg_we_out),  64'd0);
        check("rst_taken",     64'(branch_taken), 64'd0);
        check("rst_pc",        64'(pc_target_out), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single entry, 1-cycle latency, gone after the pop
        send(32'h0000_00FF, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0);
        check("lat_out_valid", 64'(out_valid), 64'd1);
        check("lat_result",    64'(result),    64'hFF);
        check("lat_fwd_valid", 64'(fwd_valid), 64'd1);
        idle();
        @(posedge clk);
        #1;
        check("after_pop_valid", 64'(out_valid), 64'd0);

        // Branch resolution and x0 suppression, back to back
        send(32'h0000_0010, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 1'b0, 1'b1); // BEQ zero
        send(32'h0000_0011, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 32'h0000_2004, 1'b0, 1'b0); // BNE zero
        send(32'h0000_0012, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0000_2008, 1'b1, 1'b0); // no branch
        send(32'h0000_0013, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1, 32'h0000_200C, 1'b0, 1'b1); // BNE nonzero
        send(32'h0000_0014, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0000_2010, 1'b0, 1'b0); // x0
        check("x0_we",        64'(reg_we_out), 64'd0);
        check("x0_fwd_valid", 64'(fwd_valid),  64'd0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("branch_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure: 1 in main, 2 in skid, 3 held upstream
        out_ready = 1'b0;
        send(32'h1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0);
        send(32'h2, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0);
        check("bp_in_ready",  64'(in_ready),  64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_main",      64'(result),    64'h1);
        alu_result = 32'h3;
        rd_addr    = 5'd3;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hold_main",  64'(result),   64'h1);
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(32'h3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h108, 1'b1, 1'b0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_back", 64'(in_ready), 64'd1);
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // Flush with both registers full and an input offered
        out_ready = 1'b0;
        send(32'hA, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0);
        send(32'hB, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 32'h204, 1'b1, 1'b0);
        alu_result = 32'hC;
        rd_addr    = 5'd12;
        in_valid   = 1'b1;
        flush      = 1'b1;
        @(posedge clk);
        exp_q.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with an entry pending
        out_ready = 1'b0;
        send(32'hDEAD_BEEF, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0);
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result",    64'(result),    64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0000_1234, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0);
        check("post_rst_valid",  64'(out_valid), 64'd1);
        check("post_rst_result", 64'(result),    64'h1234);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
